// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit display scanner: time-slots each anode with a blanking gap,
// latches new BCD values only on frame boundaries, and applies leading-zero/blink suppression.
module display_scan_ctrl #(
    parameter int unsigned SHOW_CYCLES  = 499000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_bcd,
    input  logic        blink_en,
    input  logic [3:0]  blink_mask,
    input  logic        blink_tick,
    input  logic        lz_suppress,
    output logic [3:0]  digit,
    output logic [3:0]  digit_data,
    output logic        frame_done
);
    localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic { SHOW = 1'b0, BLANK = 1'b1 } state_t;

    state_t           state_q, state_d;
    logic [1:0]       posn_q, posn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0][3:0]  active_q, pending_q;
    logic             pending_full_q, pending_full_d;
    logic             blink_phase_q, blink_phase_d;
    logic             boundary, xfer, load_active, suppress;
    logic [3:0]       digit_d;

    // Slot sequencer: SHOW then BLANK for each position, advancing posn after the gap.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        posn_d   = posn_q;
        cnt_d    = cnt_q + CNT_W'(1);
        boundary = 1'b0;
        case (state_q)
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d  = SHOW;
                    cnt_d    = '0;
                    posn_d   = posn_q + 2'd1;
                    boundary = (posn_q == 2'd3);
                end
            end
            default: ;
        endcase
    end

    // A full pending slot blocks new transfers, so the two cases are exclusive.
    always_comb begin
        xfer           = in_valid && in_ready;
        load_active    = boundary && pending_full_q;
        pending_full_d = pending_full_q;
        if (load_active) begin
            pending_full_d = 1'b0;
        end else if (xfer) begin
            pending_full_d = 1'b1;
        end
        blink_phase_d = blink_en && (blink_phase_q ^ blink_tick);
    end

    always_comb begin
        suppress = blink_phase_q && blink_mask[posn_q];
        if (lz_suppress) begin
            case (posn_q)
                2'd3:    suppress = suppress || (active_q[3] == 4'd0);
                2'd2:    suppress = suppress || (active_q[3:2] == '0);
                2'd1:    suppress = suppress || (active_q[3:1] == '0);
                default: ;
            endcase
        end
        digit_d = 4'b1111;
        if (state_q == SHOW && !suppress) begin
            digit_d = ~(4'b0001 << posn_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SHOW;
            posn_q         <= 2'd0;
            cnt_q          <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            blink_phase_q  <= 1'b0;
            digit          <= 4'b1111;
            digit_data     <= 4'd0;
            in_ready       <= 1'b1;
            frame_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            posn_q         <= posn_d;
            cnt_q          <= cnt_d;
            if (load_active) active_q <= pending_q;
            if (xfer) pending_q <= in_bcd;
            pending_full_q <= pending_full_d;
            blink_phase_q  <= blink_phase_d;
            // Ready follows the next pending state so a full slot is never overwritten.
            in_ready       <= !pending_full_d;
            digit          <= digit_d;
            digit_data     <= active_q[posn_q];
            frame_done     <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random traffic,
// compared against a frame-arithmetic reference model with a one-deep pending queue.
module tb_display_scan_ctrl;
    localparam int SHOW   = 8;
    localparam int BLANK  = 2;
    localparam int SLOT   = SHOW + BLANK;
    localparam int PERIOD = 4 * SLOT;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, blink_en = 1'b0, blink_tick = 1'b0, lz_suppress = 1'b0;
    logic [15:0] in_bcd = 16'd0;
    logic [3:0]  blink_mask = 4'd0;
    logic        in_ready, frame_done;
    logic [3:0]  digit, digit_data;

    int n_vec = 0, n_err = 0;

    // Reference model state: cycles since reset, displayed value, pending queue, blink phase.
    logic [15:0] q[$];
    logic [15:0] m_active;
    bit          m_phase, m_acc;
    int          m_j;
    logic [3:0]  exp_digit, exp_data;
    logic        exp_done, exp_ready;

    display_scan_ctrl #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .blink_en(blink_en), .blink_mask(blink_mask), .blink_tick(blink_tick),
        .lz_suppress(lz_suppress), .digit(digit), .digit_data(digit_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic model_reset();
        q.delete();
        m_active = 16'd0;
        m_phase  = 1'b0;
        m_j      = 0;
    endtask

    // Predicts the outputs registered by the next edge, advances the model, then clocks.
    task automatic tick();
        int p, slot;
        bit sup, was_empty;
        p    = m_j % PERIOD;
        slot = p / SLOT;
        sup  = (lz_suppress && slot != 0 && (m_active >> (4 * slot)) == 16'd0)
            || (m_phase && blink_mask[slot]);
        exp_digit = ((p % SLOT) >= SHOW || sup) ? 4'b1111 : ~(4'b0001 << slot);
        exp_data  = m_active[4*slot +: 4];
        exp_done  = (p == PERIOD - 1);
        was_empty = (q.size() == 0);
        m_acc     = in_valid && was_empty;
        if (p == PERIOD - 1 && !was_empty) m_active = q.pop_front();
        if (m_acc) q.push_back(in_bcd);
        if (!blink_en) m_phase = 1'b0;
        else if (blink_tick) m_phase = !m_phase;
        exp_ready = (q.size() == 0);
        m_j++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < PERIOD && (m_j % PERIOD) != target; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (digit !== 4'b1111) begin n_err++; $display("FAIL reset_digit got %b exp 1111", digit); end
        n_vec++; if (digit_data !== 4'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", digit_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", in_ready); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        n_vec++; if (digit !== 4'b1110) begin n_err++; $display("FAIL first_digit got %b exp 1110", digit); end
        n_vec++; if (digit !== exp_digit) begin n_err++; $display("FAIL first_digit_model got %b exp %b", digit, exp_digit); end
    endtask

    task automatic test_free_run();
        repeat (2 * PERIOD) begin
            tick();
            n_vec++; if (digit !== exp_digit) begin n_err++; $display("FAIL free_run_digit j=%0d got %b exp %b", m_j, digit, exp_digit); end
            n_vec++; if (frame_done !== exp_done) begin n_err++; $display("FAIL free_run_done j=%0d got %b exp %b", m_j, frame_done, exp_done); end
        end
    endtask

    task automatic test_load();
        wait_pos(15);
        in_valid = 1'b1;
        in_bcd   = 16'h1234;
        tick();
        in_valid = 1'b0;
        in_bcd   = 16'hFFFF;
        n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL load_stall got %b exp %b", in_ready, exp_ready); end
        repeat (70) begin
            tick();
            n_vec++; if (digit_data !== exp_data) begin n_err++; $display("FAIL load_data j=%0d got %h exp %h", m_j, digit_data, exp_data); end
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL load_ready j=%0d got %b exp %b", m_j, in_ready, exp_ready); end
        end
    endtask

    task automatic test_back_to_back();
        wait_pos(5);
        in_valid = 1'b1;
        in_bcd   = 16'h1111;
        tick();
        in_bcd = 16'h2222;
        for (int i = 0; i < 2 * PERIOD && in_valid; i++) begin
            tick();
            if (m_acc) in_valid = 1'b0;
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL b2b_ready j=%0d got %b exp %b", m_j, in_ready, exp_ready); end
            n_vec++; if (digit_data !== exp_data) begin n_err++; $display("FAIL b2b_data j=%0d got %h exp %h", m_j, digit_data, exp_data); end
        end
        n_vec++; if (in_valid !== 1'b0) begin n_err++; $display("FAIL b2b_accept got valid=%b exp 0 (second load never accepted)", in_valid); end
        repeat (2 * PERIOD) begin
            tick();
            n_vec++; if (digit_data !== exp_data) begin n_err++; $display("FAIL b2b_show j=%0d got %h exp %h", m_j, digit_data, exp_data); end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2];
        vals[0] = 16'h0005;
        vals[1] = 16'h0105;
        lz_suppress = 1'b1;
        for (int v = 0; v < 2; v++) begin
            in_valid = 1'b1;
            in_bcd   = vals[v];
            tick();
            in_valid = 1'b0;
            repeat (2 * PERIOD) begin
                tick();
                n_vec++; if (digit !== exp_digit) begin n_err++; $display("FAIL lz_digit val=%h j=%0d got %b exp %b", vals[v], m_j, digit, exp_digit); end
            end
        end
        lz_suppress = 1'b0;
    endtask

    task automatic test_blink();
        in_valid = 1'b1;
        in_bcd   = 16'h8765;
        tick();
        in_valid   = 1'b0;
        blink_en   = 1'b1;
        blink_mask = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            blink_tick = 1'b1;
            tick();
            blink_tick = 1'b0;
            repeat (PERIOD + 7) begin
                tick();
                n_vec++; if (digit !== exp_digit) begin n_err++; $display("FAIL blink_digit j=%0d got %b exp %b", m_j, digit, exp_digit); end
            end
        end
        blink_tick = 1'b1;
        tick();
        blink_tick = 1'b0;
        repeat (10) tick();
        blink_en = 1'b0;
        repeat (PERIOD + 3) begin
            tick();
            n_vec++; if (digit !== exp_digit) begin n_err++; $display("FAIL blink_off_digit j=%0d got %b exp %b", m_j, digit, exp_digit); end
        end
    endtask

    task automatic test_random();
        repeat (800) begin
            in_valid    = ($urandom_range(0, 3) == 0);
            in_bcd      = 16'($urandom);
            lz_suppress = 1'($urandom_range(0, 1));
            blink_en    = ($urandom_range(0, 7) != 0);
            blink_mask  = 4'($urandom);
            blink_tick  = ($urandom_range(0, 15) == 0);
            tick();
            n_vec++; if (digit !== exp_digit) begin n_err++; $display("FAIL rand_digit j=%0d got %b exp %b", m_j, digit, exp_digit); end
            n_vec++; if (digit_data !== exp_data) begin n_err++; $display("FAIL rand_data j=%0d got %h exp %h", m_j, digit_data, exp_data); end
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rand_ready j=%0d got %b exp %b", m_j, in_ready, exp_ready); end
            n_vec++; if (frame_done !== exp_done) begin n_err++; $display("FAIL rand_done j=%0d got %b exp %b", m_j, frame_done, exp_done); end
        end
        in_valid = 1'b0; lz_suppress = 1'b0; blink_en = 1'b0; blink_mask = 4'd0; blink_tick = 1'b0;
    endtask

    task automatic test_reset_mid();
        wait_pos(PERIOD - 1);
        tick();
        in_valid = 1'b1;
        in_bcd   = 16'hABCD;
        tick();
        in_valid = 1'b0;
        wait_pos(12);
        tick();
        n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL mid_pending_full got %b exp %b", in_ready, exp_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (digit !== 4'b1111) begin n_err++; $display("FAIL mid_reset_digit got %b exp 1111", digit); end
        n_vec++; if (digit_data !== 4'd0) begin n_err++; $display("FAIL mid_reset_data got %h exp 0", digit_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready got %b exp 1", in_ready); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL mid_reset_done got %b exp 0", frame_done); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        n_vec++; if (digit !== 4'b1110) begin n_err++; $display("FAIL mid_first_digit got %b exp 1110", digit); end
        repeat (PERIOD + 10) begin
            tick();
            n_vec++; if (digit_data !== exp_data) begin n_err++; $display("FAIL mid_discard_data j=%0d got %h exp %h", m_j, digit_data, exp_data); end
            n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL mid_discard_ready j=%0d got %b exp %b", m_j, in_ready, exp_ready); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_free_run();
        test_load();
        test_back_to_back();
        test_lz();
        test_blink();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SHOW_CYCLES, default 499000: clk cycles each digit's anode is driven per slot; legal range >=1.
REQ-002 Parameter BLANK_CYCLES, default 1000: clk cycles all anodes are off between slots (anti-ghosting); legal range >=1.
REQ-003 Port clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1: asynchronous, active-low reset.
REQ-005 Port in_valid  in  1: the producer offers in_bcd this cycle.
REQ-006 Port in_ready  out  1: the block can accept in_bcd this cycle.
REQ-007 Port in_bcd  in  16: {thousands, hundreds, tens, units}, 4 bits each.
REQ-008 Port blink_en  in  1: enables blinking of the masked digits (adjust mode).
REQ-009 Port blink_mask  in  4: bit i set means digit i blinks; bit 0 is units.
REQ-010 Port blink_tick  in  1: single-cycle pulse that toggles the blink phase.
REQ-011 Port lz_suppress  in  1: blanks leading zeros when high.
REQ-012 Port digit  out  4: active-low anode enables; bit 0 is units.
REQ-013 Port digit_data  out  4: nibble for the digit currently being driven, feeding the segment decoder.
REQ-014 Port frame_done  out  1: one-cycle pulse marking the end of each 4-digit frame.

Function
REQ-015 The FSM SHALL have two states, SHOW and BLANK, with a 2-bit slot position posn (0 = units … 3 = thousands) and a slot counter cnt.
REQ-016 In SHOW, cnt SHALL count 0..SHOW_CYCLES-1; on the terminal count the FSM SHALL move to BLANK with cnt=0.
REQ-017 In BLANK, cnt SHALL count 0..BLANK_CYCLES-1; on the terminal count the FSM SHALL move to SHOW with cnt=0 and posn+1, wrapping from 3 to 0.
REQ-018 Frame period SHALL be exactly 4*(SHOW_CYCLES+BLANK_CYCLES) cycles.
REQ-019 The frame boundary is the terminal BLANK cycle with posn=3; frame_done SHALL be high in the cycle after it, for exactly one cycle.
REQ-020 Input handshake: a transfer occurs when in_valid and in_ready are both high at a rising edge; in_bcd SHALL then be captured into a pending register and pending_full set.
REQ-021 in_ready SHALL equal NOT pending_full, registered.
REQ-022 At the frame boundary, if pending_full is set, the pending value SHALL move to the active register and pending_full SHALL clear; the displayed value therefore never changes mid-frame.
REQ-023 A transfer in the same cycle as the frame boundary with pending empty SHALL land in pending and be displayed from the following frame.
REQ-024 With a valid offered while pending is full, the producer SHALL be held off (in_ready=0) and no data SHALL be lost or overwritten.
REQ-025 In SHOW, digit SHALL drive low exactly the anode of posn (1110, 1101, 1011, 0111 for posn 0..3) unless that digit is suppressed; in BLANK, digit SHALL be 1111.
REQ-026 digit_data SHALL be the active-register nibble for posn, including nibbles >9, which pass through unmodified.
REQ-027 Leading-zero suppression (lz_suppress=1): thousands is suppressed if it is 0; hundreds if thousands and hundreds are 0; tens if the top three are 0; units is never suppressed.
REQ-028 Blink phase SHALL toggle on each blink_tick while blink_en=1 and SHALL be forced to 0 while blink_en=0.
REQ-029 When the blink phase is 1, every digit with its blink_mask bit set SHALL be suppressed.
REQ-030 A suppressed digit keeps its slot timing with its anode held at 1.
REQ-031 digit, digit_data, in_ready and frame_done SHALL be registered, and SHALL reflect FSM/posn state with exactly one cycle of latency.

Reset
REQ-032 While rst_n=0, the block SHALL hold: state=SHOW, posn=0, cnt=0, active register=0, pending_full=0, blink phase=0.
REQ-033 While rst_n=0, the outputs SHALL be: digit=1111, digit_data=0, in_ready=1, frame_done=0.
REQ-034 On rst_n asserting mid-frame or mid-handshake, the block SHALL abandon the frame and discard pending data immediately (asynchronously).
REQ-035 In the first cycle after rst_n deasserts, the block SHALL drive digit=1110.

Verification (SHOW_CYCLES=8, BLANK_CYCLES=2)
REQ-036 Free run after reset -> digit sequence 1110x8, 1111x2, 1101x8, 1111x2, 1011x8, 1111x2, 0111x8, 1111x2; frame_done pulses every 40 cycles.
REQ-037 Load 16'h1234 mid-frame -> digit_data stays 0 until the next frame boundary, then reads 4,3,2,1 per slot; in_ready returns to 1 at the boundary.
REQ-038 Two back-to-back loads 16'h1111 then 16'h2222 within one frame -> the second is stalled (in_ready=0) until the boundary, 1111 is shown for one frame, then 2222.
REQ-039 lz_suppress=1 with 16'h0005 -> only units slot asserts its anode (1110); with 16'h0105, hundreds, tens and units asserted, thousands stays 1111.
REQ-040 blink_en=1, blink_mask=4'b0011, one blink_tick -> units/tens anodes stay 1111 until the next tick; blink_en=0 -> all restored.
REQ-041 rst_n pulsed low during the tens slot with pending full -> outputs at reset values immediately; pending discarded, in_ready=1.
